sc_pulse_decoder: RTL

Receive-side counterpart of the stochastic pulse-width encoder. It watches a single-bit stream, measures the length of each high run, and regenerates a one-cycle pulse for every run of legal width. It also delivers each measured length, with a pass/fail flag, through a valid/ready result port. It sits between the bit-stream fabric and downstream counters/accumulators that need discrete events rather than stretched levels.

---
 rtl/sc_pulse_decoder_pkg.sv | 13 +
 rtl/sc_pulse_decoder_if.sv | 12 +
 rtl/sc_pulse_decoder_sat_counter.sv | 24 ++
 rtl/sc_pulse_decoder.sv | 109 ++++++++++
 4 files changed

// File: rtl/sc_pulse_decoder_pkg.sv
// Shared types and defaults for the stochastic pulse-width decoder family.
package sc_pkg;

   localparam int unsigned SC_CNT_W = 16;

   typedef enum logic [1:0] {IDLE, RUN, LONG} pd_state_t;

   typedef struct packed {
      logic [SC_CNT_W-1:0] len;
      logic                ok;
   } pd_result_t;

endpackage

// File: rtl/sc_pulse_decoder_if.sv
// Valid/ready result port carrying one measured run length and its pass/fail flag.
interface sc_pulse_decoder_if #(
   parameter int unsigned CNT_W = sc_pkg::SC_CNT_W
);
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] res_len;
   logic             res_ok;

   modport master (output res_valid, output res_len, output res_ok, input res_ready);
   modport slave  (input res_valid, input res_len, input res_ok, output res_ready);
endinterface

// File: rtl/sc_pulse_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear and load; clear wins over load, load over increment.
module sc_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/sc_pulse_decoder.sv
// Measures high runs on bit_stream, emits one pulse per legal run and queues each
// measured length in a single-entry valid/ready result register.
module sc_pulse_decoder
   import sc_pkg::*;
#(
   parameter int unsigned CNT_W   = SC_CNT_W,
   parameter int unsigned MIN_LEN = 4,
   parameter int unsigned MAX_LEN = 110
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bit_stream,
   output logic                pulse_out,
   output logic                overrun,
   sc_pulse_decoder_if.master  res
);

   if (64'(MAX_LEN) + 64'd1 > (64'd1 << CNT_W) - 64'd1) begin : g_bad_max
      $error("sc_pulse_decoder: MAX_LEN+1 does not fit below counter saturation");
   end
   if (MIN_LEN < 1 || MIN_LEN > MAX_LEN) begin : g_bad_min
      $error("sc_pulse_decoder: MIN_LEN must lie in [1, MAX_LEN]");
   end

   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] FAIL_LEN = CNT_W'(MAX_LEN + 1);

   pd_state_t        state;
   logic             bs_q;
   logic [CNT_W-1:0] cnt;
   logic             rise;
   logic             cnt_clr;
   logic             cnt_load;
   logic             cnt_inc;
   logic             over_max;
   logic             prod;
   logic             prod_pulse;
   logic             prod_ok;
   logic [CNT_W-1:0] prod_len;

   sc_sat_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (CNT_W'(1)),
      .inc      (cnt_inc),
      .q        (cnt)
   );

   always_comb begin
      rise       = bit_stream && !bs_q;
      cnt_load   = (state == IDLE) && rise;
      cnt_inc    = (state != IDLE) && bit_stream;
      cnt_clr    = (state != IDLE) && !bit_stream;
      // cnt+1 > MAX_LEN rewritten so it cannot overflow the counter width
      over_max   = (cnt >= MAX_C);
      prod       = 1'b0;
      prod_pulse = 1'b0;
      prod_len   = cnt;
      prod_ok    = 1'b1;
      if (state == RUN && !bit_stream && cnt >= MIN_C) begin
         prod       = 1'b1;
         prod_pulse = 1'b1;
      end
      if (state == LONG && !bit_stream) begin
         prod     = 1'b1;
         prod_len = FAIL_LEN;
         prod_ok  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bs_q          <= 1'b1;
         pulse_out     <= 1'b0;
         overrun       <= 1'b0;
         res.res_valid <= 1'b0;
         res.res_len   <= '0;
         res.res_ok    <= 1'b0;
      end else begin
         bs_q      <= bit_stream;
         pulse_out <= prod_pulse;

         case (state)
            IDLE:    if (rise) state <= RUN;
            RUN:     if (!bit_stream) state <= IDLE;
                     else if (over_max) state <= LONG;
            LONG:    if (!bit_stream) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (prod) begin
            if (!res.res_valid || res.res_ready) begin
               res.res_valid <= 1'b1;
               res.res_len   <= prod_len;
               res.res_ok    <= prod_ok;
            end else begin
               overrun <= 1'b1;
            end
         end else if (res.res_valid && res.res_ready) begin
            res.res_valid <= 1'b0;
         end
      end
   end

endmodule
